// File: rtl/control_seq.sv
// control_seq: multi-cycle control sequencer for an RV32I subset.
// One instruction at a time walks IDLE -> EXEC -> (MEM -> WB) -> IDLE.
// Illegal encodings and memory timeouts park the sequencer in TRAP until trap_clr.
// Optional build macro CONTROL_SEQ_JUMP_EN: when defined, JAL and JALR (funct3 000) are legal.
// When it is undefined, both jump opcodes decode as illegal.
module control_seq #(
  parameter int MEM_TIMEOUT = 8,
  parameter int TIMEOUT_W   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ins_valid,
  output logic        ins_ready,
  input  logic [31:0] instr,
  input  logic        dmem_ack,
  input  logic        trap_clr,
  output logic        alu_imm,
  output logic [2:0]  alu_op,
  output logic        alu_alt,
  output logic        reg_wen,
  output logic [1:0]  pc_imm,
  output logic        pc_wen,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic        dmem_reg,
  output logic        op_illegal,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic        busy
);

  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_OP_IMM = 5'b00100;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
`ifdef CONTROL_SEQ_JUMP_EN
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
`endif

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SLT  = 3'b010;
  localparam logic [2:0] ALU_SLTU = 3'b011;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    EXEC,
    MEM,
    WB,
    TRAP
  } state_t;

  state_t               state;
  logic [31:0]          ir;
  logic [TIMEOUT_W-1:0] mem_cnt;
  logic [TIMEOUT_W-1:0] cnt_inc;
  logic                 pc_wen_q;

  // The decoder looks at the incoming word only while it is being accepted;
  // in every later state it sees the latched ir, so instr is free to move.
  logic [31:0] dec_word;
  logic [4:0]  dec_opc;
  logic [2:0]  dec_f3;
  logic        dec_alu_imm;
  logic [2:0]  dec_alu_op;
  logic        dec_alu_alt;
  logic        dec_reg_wen;
  logic [1:0]  dec_pc_imm;
  logic        dec_pc_wen;
  logic        dec_read;
  logic        dec_write;
  logic        dec_illegal;

  // Register numbers and immediates are handled by the datapath, not here.
  logic unused_fields;

  assign dec_word      = (state == IDLE) ? instr : ir;
  assign dec_opc       = dec_word[6:2];
  assign dec_f3        = dec_word[14:12];
  assign unused_fields = ^{dec_word[31], dec_word[29:15], dec_word[11:7]};
  assign cnt_inc       = mem_cnt + TIMEOUT_W'(1);

  // Instruction decode: EXEC-cycle control values for the word in dec_word.
  always_comb begin
    dec_alu_imm = 1'b0;
    dec_alu_op  = ALU_ADD;
    dec_alu_alt = 1'b0;
    dec_reg_wen = 1'b0;
    dec_pc_imm  = 2'b00;
    dec_pc_wen  = 1'b0;
    dec_read    = 1'b0;
    dec_write   = 1'b0;
    dec_illegal = 1'b0;
    if (dec_word[1:0] != 2'b11) begin
      dec_illegal = 1'b1;
    end else begin
      case (dec_opc)
        OPC_OP_IMM, OPC_OP: begin
          dec_alu_imm = (dec_opc == OPC_OP_IMM);
          dec_alu_op  = dec_f3;
          dec_alu_alt = dec_word[30];
          dec_reg_wen = 1'b1;
          dec_pc_wen  = 1'b1;
        end
        OPC_BRANCH: begin
          dec_pc_wen = 1'b1;
          case (dec_f3)
            3'b000: begin dec_alu_op = ALU_ADD;  dec_alu_alt = 1'b1; dec_pc_imm = 2'b11; end
            3'b001: begin dec_alu_op = ALU_ADD;  dec_alu_alt = 1'b1; dec_pc_imm = 2'b01; end
            3'b100: begin dec_alu_op = ALU_SLT;  dec_pc_imm = 2'b01; end
            3'b101: begin dec_alu_op = ALU_SLT;  dec_pc_imm = 2'b11; end
            3'b110: begin dec_alu_op = ALU_SLTU; dec_pc_imm = 2'b01; end
            3'b111: begin dec_alu_op = ALU_SLTU; dec_pc_imm = 2'b11; end
            default: begin
              dec_pc_wen  = 1'b0;
              dec_illegal = 1'b1;
            end
          endcase
        end
        OPC_LOAD: begin
          dec_alu_imm = 1'b1;
          dec_read    = 1'b1;
        end
        OPC_STORE: begin
          dec_alu_imm = 1'b1;
          dec_write   = 1'b1;
        end
`ifdef CONTROL_SEQ_JUMP_EN
        OPC_JAL: begin
          dec_reg_wen = 1'b1;
          dec_pc_wen  = 1'b1;
          dec_pc_imm  = 2'b10;
        end
        OPC_JALR: begin
          if (dec_f3 == 3'b000) begin
            dec_alu_imm = 1'b1;
            dec_reg_wen = 1'b1;
            dec_pc_wen  = 1'b1;
            dec_pc_imm  = 2'b10;
          end else begin
            dec_illegal = 1'b1;
          end
        end
`endif
        default: dec_illegal = 1'b1;
      endcase
    end
  end

  // Sequencer FSM; control outputs are registered one cycle ahead of the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ir         <= '0;
      mem_cnt    <= '0;
      trap_cause <= CAUSE_NONE;
      alu_imm    <= 1'b0;
      alu_op     <= ALU_ADD;
      alu_alt    <= 1'b0;
      reg_wen    <= 1'b0;
      pc_imm     <= 2'b00;
      pc_wen_q   <= 1'b0;
      dmem_read  <= 1'b0;
      dmem_write <= 1'b0;
      dmem_reg   <= 1'b0;
      op_illegal <= 1'b0;
    end else begin
      alu_imm    <= 1'b0;
      alu_op     <= ALU_ADD;
      alu_alt    <= 1'b0;
      reg_wen    <= 1'b0;
      pc_imm     <= 2'b00;
      pc_wen_q   <= 1'b0;
      dmem_read  <= 1'b0;
      dmem_write <= 1'b0;
      dmem_reg   <= 1'b0;
      op_illegal <= 1'b0;
      case (state)
        IDLE: begin
          if (ins_valid) begin
            ir         <= instr;
            state      <= EXEC;
            alu_imm    <= dec_alu_imm;
            alu_op     <= dec_alu_op;
            alu_alt    <= dec_alu_alt;
            reg_wen    <= dec_reg_wen;
            pc_imm     <= dec_pc_imm;
            pc_wen_q   <= dec_pc_wen;
            dmem_read  <= dec_read;
            dmem_write <= dec_write;
            op_illegal <= dec_illegal;
          end
        end
        EXEC: begin
          if (dec_illegal) begin
            state      <= TRAP;
            trap_cause <= CAUSE_ILLEGAL;
          end else if (dec_read || dec_write) begin
            state      <= MEM;
            mem_cnt    <= '0;
            alu_imm    <= alu_imm;
            alu_op     <= alu_op;
            alu_alt    <= alu_alt;
            dmem_read  <= dmem_read;
            dmem_write <= dmem_write;
          end else begin
            state <= IDLE;
          end
        end
        MEM: begin
          if (dmem_ack) begin
            if (dmem_read) begin
              state    <= WB;
              reg_wen  <= 1'b1;
              dmem_reg <= 1'b1;
              pc_wen_q <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else if (cnt_inc == TIMEOUT_W'(MEM_TIMEOUT)) begin
            state      <= TRAP;
            trap_cause <= CAUSE_TIMEOUT;
            mem_cnt    <= cnt_inc;
          end else begin
            mem_cnt    <= cnt_inc;
            alu_imm    <= alu_imm;
            alu_op     <= alu_op;
            alu_alt    <= alu_alt;
            dmem_read  <= dmem_read;
            dmem_write <= dmem_write;
          end
        end
        WB: begin
          state <= IDLE;
        end
        TRAP: begin
          if (trap_clr) begin
            state      <= IDLE;
            trap_cause <= CAUSE_NONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A store retires in the very cycle its ack arrives, so that pc_wen pulse
  // has to follow dmem_ack directly rather than wait for a register.
  assign pc_wen    = pc_wen_q | ((state == MEM) & dmem_write & dmem_ack);
  assign ins_ready = (state == IDLE);
  assign trap      = (state == TRAP);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_control_seq.sv
// tb_control_seq: randomized self-checking bench for control_seq.
// A per-instruction reference model expands each accepted word into the
// cycle-by-cycle output trace the sequencer should produce.
module tb_control_seq;

  localparam int MEM_TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ins_valid = 1'b0;
  logic        ins_ready;
  logic [31:0] instr = '0;
  logic        dmem_ack = 1'b0;
  logic        trap_clr = 1'b0;
  logic        alu_imm;
  logic [2:0]  alu_op;
  logic        alu_alt;
  logic        reg_wen;
  logic [1:0]  pc_imm;
  logic        pc_wen;
  logic        dmem_read;
  logic        dmem_write;
  logic        dmem_reg;
  logic        op_illegal;
  logic        trap;
  logic [1:0]  trap_cause;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       ins_ready;
    logic       busy;
    logic       trap;
    logic [1:0] cause;
    logic       ill;
    logic       alu_imm;
    logic [2:0] alu_op;
    logic       alu_alt;
    logic       reg_wen;
    logic [1:0] pc_imm;
    logic       pc_wen;
    logic       rd;
    logic       wr;
    logic       dreg;
  } ovec_t;

  typedef struct packed {
    ovec_t v;
    logic  ack;
    logic  clr;
  } step_t;

  ovec_t obs;
  step_t trace[$];

  // Branch behaviour straight from the branch table, indexed by funct3 (-1 = illegal).
  int         br_op [8] = '{0, 0, -1, -1, 2, 2, 3, 3};
  bit         br_alt[8] = '{1, 1, 0, 0, 0, 0, 0, 0};
  logic [1:0] br_pc [8] = '{2'b11, 2'b01, 2'b00, 2'b00, 2'b01, 2'b11, 2'b01, 2'b11};

  assign obs = {ins_ready, busy, trap, trap_cause, op_illegal, alu_imm, alu_op, alu_alt,
                reg_wen, pc_imm, pc_wen, dmem_read, dmem_write, dmem_reg};

  control_seq #(.MEM_TIMEOUT(MEM_TIMEOUT), .TIMEOUT_W(4)) dut (
    .clk(clk), .rst(rst), .ins_valid(ins_valid), .ins_ready(ins_ready), .instr(instr),
    .dmem_ack(dmem_ack), .trap_clr(trap_clr), .alu_imm(alu_imm), .alu_op(alu_op),
    .alu_alt(alu_alt), .reg_wen(reg_wen), .pc_imm(pc_imm), .pc_wen(pc_wen),
    .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_reg(dmem_reg),
    .op_illegal(op_illegal), .trap(trap), .trap_cause(trap_cause), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic ovec_t v_idle();
    ovec_t v = '0;
    v.ins_ready = 1'b1;
    return v;
  endfunction

  function automatic ovec_t v_trap(input logic [1:0] cause);
    ovec_t v = '0;
    v.busy  = 1'b1;
    v.trap  = 1'b1;
    v.cause = cause;
    return v;
  endfunction

  function automatic logic noisy(input bit en);
    return en ? 1'($urandom_range(0, 1)) : 1'b0;
  endfunction

  function automatic void push_step(input ovec_t v, input logic ack, input logic clr);
    step_t s;
    s.v   = v;
    s.ack = ack;
    s.clr = clr;
    trace.push_back(s);
  endfunction

  // Random word of a chosen class: 0 OP_IMM, 1 OP, 2 BRANCH, 3 LOAD, 4 STORE, 5 JAL, 6 JALR, else bad low bits.
  function automatic logic [31:0] rand_word(input int kind);
    logic [31:0] w = $urandom;
    case (kind)
      0: w[6:0] = 7'b0010011;
      1: w[6:0] = 7'b0110011;
      2: w[6:0] = 7'b1100011;
      3: w[6:0] = 7'b0000011;
      4: w[6:0] = 7'b0100011;
      5: w[6:0] = 7'b1101111;
      6: w[6:0] = 7'b1100111;
      default: w[1:0] = 2'($urandom_range(0, 2));
    endcase
    return w;
  endfunction

  // Reference model: expected outputs for every cycle after acceptance, ending with the IDLE cycle.
  // ack_at is the MEM cycle (1-based) on which dmem_ack is raised; 0 means never.
  task automatic model_trace(input logic [31:0] w, input int ack_at, input bit noise);
    ovec_t      e;
    ovec_t      m;
    logic [4:0] opc;
    logic [2:0] f3;
    bit         ill;
    bit         is_ld;
    bit         is_st;
    bit         acked;
    int         nmem;
    opc   = w[6:2];
    f3    = w[14:12];
    e     = '0;
    e.busy = 1'b1;
    ill   = 1'b0;
    is_ld = 1'b0;
    is_st = 1'b0;
    trace.delete();
    if (w[1:0] != 2'b11) ill = 1'b1;
    else if (opc == 5'b00100 || opc == 5'b01100) begin
      e.alu_imm = (opc == 5'b00100);
      e.alu_op  = f3;
      e.alu_alt = w[30];
      e.reg_wen = 1'b1;
      e.pc_wen  = 1'b1;
    end else if (opc == 5'b11000) begin
      if (br_op[f3] < 0) ill = 1'b1;
      else begin
        e.alu_op  = 3'(br_op[f3]);
        e.alu_alt = br_alt[f3];
        e.pc_imm  = br_pc[f3];
        e.pc_wen  = 1'b1;
      end
    end else if (opc == 5'b00000) begin
      is_ld = 1'b1; e.alu_imm = 1'b1; e.rd = 1'b1;
    end else if (opc == 5'b01000) begin
      is_st = 1'b1; e.alu_imm = 1'b1; e.wr = 1'b1;
    end
`ifdef CONTROL_SEQ_JUMP_EN
    else if (opc == 5'b11011 || (opc == 5'b11001 && f3 == 3'b000)) begin
      e.alu_imm = (opc == 5'b11001);
      e.reg_wen = 1'b1;
      e.pc_imm  = 2'b10;
      e.pc_wen  = 1'b1;
    end
`endif
    else ill = 1'b1;
    if (ill) begin
      e      = '0;
      e.busy = 1'b1;
      e.ill  = 1'b1;
    end
    push_step(e, noisy(noise), 1'b0);
    if (ill) begin
      push_step(v_trap(2'b01), noisy(noise), 1'b0);
      push_step(v_trap(2'b01), noisy(noise), 1'b1);
    end else if (is_ld || is_st) begin
      acked = (ack_at >= 1 && ack_at <= MEM_TIMEOUT);
      nmem  = acked ? ack_at : MEM_TIMEOUT;
      for (int k = 1; k <= nmem; k++) begin
        m = e;
        if (is_st && acked && k == ack_at) m.pc_wen = 1'b1;
        push_step(m, (acked && k == ack_at), 1'b0);
      end
      if (!acked) begin
        push_step(v_trap(2'b10), noisy(noise), 1'b0);
        push_step(v_trap(2'b10), noisy(noise), 1'b1);
      end else if (is_ld) begin
        m         = '0;
        m.busy    = 1'b1;
        m.reg_wen = 1'b1;
        m.dreg    = 1'b1;
        m.pc_wen  = 1'b1;
        push_step(m, noisy(noise), 1'b0);
      end
    end
    push_step(v_idle(), noisy(noise), 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; ins_valid = 1'b1; instr = 32'h0050_0093; dmem_ack = 1'b1; trap_clr = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs !== v_idle()) begin
      errors++;
      $display("[TB] FAIL reset_held: got %h expected %h", obs, v_idle());
    end
    rst = 1'b0; ins_valid = 1'b0; dmem_ack = 1'b0; trap_clr = 1'b0;
    @(negedge clk);
    checks++;
    if (obs !== v_idle()) begin
      errors++;
      $display("[TB] FAIL reset_release: got %h expected %h", obs, v_idle());
    end
    tick();
  endtask

  task automatic test_alu_branch();
    logic [31:0] w;
    for (int i = 0; i < 24; i++) begin
      w = (i == 0) ? 32'h0050_0093 : rand_word(i % 3);
      model_trace(w, 0, 1'b1);
      instr = w; ins_valid = 1'b1; dmem_ack = noisy(1'b1);
      @(negedge clk);
      checks++;
      if (obs !== v_idle()) begin
        errors++;
        $display("[TB] FAIL alu_accept %h: got %h expected %h", w, obs, v_idle());
      end
      tick();
      ins_valid = 1'b0;
      for (int s = 0; s < trace.size(); s++) begin
        dmem_ack = trace[s].ack; trap_clr = trace[s].clr; instr = $urandom;
        @(negedge clk);
        checks++;
        if (obs !== trace[s].v) begin
          errors++;
          $display("[TB] FAIL alu %h step %0d: got %h expected %h", w, s, obs, trace[s].v);
        end
        tick();
      end
    end
  endtask

  task automatic test_memory();
    logic [31:0] w;
    int          ack_at;
    for (int i = 0; i < 20; i++) begin
      case (i)
        0:       begin w = 32'h0000_A103; ack_at = 3; end
        1:       begin w = rand_word(3);  ack_at = 1; end
        2:       begin w = rand_word(4);  ack_at = MEM_TIMEOUT; end
        3:       begin w = rand_word(3);  ack_at = MEM_TIMEOUT; end
        4:       begin w = 32'h0020_A023; ack_at = 0; end
        5:       begin w = rand_word(3);  ack_at = 0; end
        default: begin w = rand_word(3 + (i % 2)); ack_at = int'($urandom_range(1, MEM_TIMEOUT)); end
      endcase
      model_trace(w, ack_at, 1'b1);
      instr = w; ins_valid = 1'b1; dmem_ack = noisy(1'b1);
      @(negedge clk);
      checks++;
      if (obs !== v_idle()) begin
        errors++;
        $display("[TB] FAIL mem_accept %h: got %h expected %h", w, obs, v_idle());
      end
      tick();
      ins_valid = 1'b0;
      for (int s = 0; s < trace.size(); s++) begin
        dmem_ack = trace[s].ack; trap_clr = trace[s].clr; instr = $urandom;
        @(negedge clk);
        checks++;
        if (obs !== trace[s].v) begin
          errors++;
          $display("[TB] FAIL mem %h ack@%0d step %0d: got %h expected %h", w, ack_at, s, obs, trace[s].v);
        end
        tick();
      end
    end
  endtask

  task automatic test_illegal_jump();
    logic [31:0] w;
    for (int i = 0; i < 14; i++) begin
      case (i)
        0:       w = 32'h0000_006F;
        1:       w = 32'h0020_A063;
        2:       w = 32'h0020_B063;
        3:       w = 32'h0000_0067;
        4:       w = 32'h0000_1067;
        default: w = rand_word(5 + (i % 3));
      endcase
      model_trace(w, 0, 1'b1);
      instr = w; ins_valid = 1'b1; dmem_ack = noisy(1'b1);
      @(negedge clk);
      checks++;
      if (obs !== v_idle()) begin
        errors++;
        $display("[TB] FAIL ill_accept %h: got %h expected %h", w, obs, v_idle());
      end
      tick();
      ins_valid = 1'b0;
      for (int s = 0; s < trace.size(); s++) begin
        dmem_ack = trace[s].ack; trap_clr = trace[s].clr; instr = $urandom;
        @(negedge clk);
        checks++;
        if (obs !== trace[s].v) begin
          errors++;
          $display("[TB] FAIL ill %h step %0d: got %h expected %h", w, s, obs, trace[s].v);
        end
        tick();
      end
    end
  endtask

  task automatic test_reset_priority();
    logic [31:0] w;
    for (int pass = 0; pass < 2; pass++) begin
      w = (pass == 0) ? 32'h0000_A103 : 32'h0020_A063;
      model_trace(w, 0, 1'b0);
      instr = w; ins_valid = 1'b1;
      tick();
      ins_valid = 1'b0;
      for (int s = 0; s < ((pass == 0) ? 4 : 2); s++) begin
        dmem_ack = trace[s].ack; trap_clr = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== trace[s].v) begin
          errors++;
          $display("[TB] FAIL rstprio %h step %0d: got %h expected %h", w, s, obs, trace[s].v);
        end
        tick();
      end
      rst = 1'b1; dmem_ack = 1'b1;
      tick();
      rst = 1'b0; dmem_ack = 1'b0;
      @(negedge clk);
      checks++;
      if (obs !== v_idle()) begin
        errors++;
        $display("[TB] FAIL rstprio_after %h: got %h expected %h", w, obs, v_idle());
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w;
    int          ack_at;
    step_t       last;
    w = rand_word(0); ack_at = 0;
    instr = w; ins_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (obs !== v_idle()) begin
      errors++;
      $display("[TB] FAIL b2b_first: got %h expected %h", obs, v_idle());
    end
    tick();
    for (int k = 0; k < 40; k++) begin
      model_trace(w, ack_at, 1'b1);
      last = trace.pop_back();
      for (int s = 0; s < trace.size(); s++) begin
        dmem_ack = trace[s].ack; trap_clr = trace[s].clr; instr = $urandom;
        @(negedge clk);
        checks++;
        if (obs !== trace[s].v) begin
          errors++;
          $display("[TB] FAIL b2b %h step %0d: got %h expected %h", w, s, obs, trace[s].v);
        end
        tick();
      end
      w      = rand_word(int'($urandom_range(0, 7)));
      ack_at = int'($urandom_range(0, MEM_TIMEOUT));
      instr = w; dmem_ack = last.ack; trap_clr = 1'b0;
      if (k == 39) ins_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (obs !== last.v) begin
        errors++;
        $display("[TB] FAIL b2b_idle %0d: got %h expected %h", k, obs, last.v);
      end
      tick();
    end
    ins_valid = 1'b0; dmem_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_alu_branch();
    test_memory();
    test_illegal_jump();
    test_reset_priority();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
